eth_phy_10g_rx_block_lock_ctrl: RTL and testbench

- Block-lock controller for the 10GBASE-R receive path. Implements a simplified IEEE 802.3 Clause 49 lock state machine.
- Watches the 2-bit sync headers delivered by the RX frame aligner.
- Drives the aligner's bitslip request until 64 consecutive valid headers are seen, then asserts block lock.
- Drops lock and resumes slipping when the invalid-header rate in a 64-header window reaches 16. Sits between the frame aligner and the PCS descrambler/decoder.

---
 rtl/eth_phy_10g_rx_block_lock_ctrl_if.sv | 24 ++
 rtl/eth_phy_10g_rx_block_lock_ctrl.sv | 163 ++++++++++++++++
 tb/tb_eth_phy_10g_rx_block_lock_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/eth_phy_10g_rx_block_lock_ctrl_if.sv
// Aligner <-> block-lock controller link.
//   i_rx_hdr       : sync header from the frame aligner
//   i_rx_hdr_valid : i_rx_hdr carries a new header this cycle
//   o_bitslip      : one-cycle slip request back to the aligner
// master = aligner side, slave = block-lock controller side.
interface eth_phy_10g_rx_block_lock_ctrl_if #(
  parameter int unsigned HDR_WIDTH = 2
);
  logic [HDR_WIDTH-1:0] i_rx_hdr;
  logic                 i_rx_hdr_valid;
  logic                 o_bitslip;

  modport master (
    output i_rx_hdr,
    output i_rx_hdr_valid,
    input  o_bitslip
  );

  modport slave (
    input  i_rx_hdr,
    input  i_rx_hdr_valid,
    output o_bitslip
  );
endinterface

// File: rtl/eth_phy_10g_rx_block_lock_ctrl.sv
// 10GBASE-R receive block-lock controller (simplified Clause 49 lock FSM).
// Slips the frame aligner until a full window of valid sync headers is seen,
// then holds block lock until a window collects too many invalid headers.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_enable          : 0 parks the FSM in RESET_CNT with lock deasserted
//   aln (slave)       : header/valid from aligner, bitslip request to it
//   o_rx_block_lock   : block lock status (registered)
//   o_slip_pos        : slips performed modulo FRAME_WIDTH
//   o_lock_loss_cnt   : saturating count of lock -> unlock transitions
module eth_phy_10g_rx_block_lock_ctrl #(
  parameter int unsigned HDR_WIDTH      = 2,
  parameter int unsigned FRAME_WIDTH    = 66,
  parameter int unsigned SH_POS_WIDTH   = $clog2(FRAME_WIDTH),
  parameter int unsigned SH_CNT_MAX     = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_enable,
  eth_phy_10g_rx_block_lock_ctrl_if.slave aln,
  output logic                            o_rx_block_lock,
  output logic [SH_POS_WIDTH-1:0]         o_slip_pos,
  output logic [15:0]                     o_lock_loss_cnt
);

  localparam int unsigned SH_CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned SH_INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned WAIT_W    = $clog2(SLIP_WAIT + 1);
  localparam int unsigned LOSS_W    = 16;

  typedef enum logic [1:0] {
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [SH_CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [SH_INV_W-1:0]   sh_inv_cnt_q, sh_inv_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  bitslip_q, bitslip_d;
  logic                  block_lock_q, block_lock_d;
  logic [SH_POS_WIDTH-1:0] slip_pos_q, slip_pos_d;
  logic [LOSS_W-1:0]     lock_loss_cnt_q, lock_loss_cnt_d;

  logic [HDR_WIDTH-1:0]  hdr;
  logic                  hdr_ok;
  logic                  win_done;
  logic                  inv_hit;

  assign hdr      = aln.i_rx_hdr;
  // Only 01 and 10 are legal sync headers.
  assign hdr_ok   = (hdr == HDR_WIDTH'(1)) || (hdr == HDR_WIDTH'(2));
  // This strobed header closes the window / reaches the invalid threshold.
  assign win_done = (sh_cnt_q == SH_CNT_W'(SH_CNT_MAX - 1));
  assign inv_hit  = !hdr_ok && (sh_inv_cnt_q == SH_INV_W'(SH_INVALID_MAX - 1));

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_RESET_CNT;
      sh_cnt_q        <= '0;
      sh_inv_cnt_q    <= '0;
      wait_cnt_q      <= '0;
      bitslip_q       <= 1'b0;
      block_lock_q    <= 1'b0;
      slip_pos_q      <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      sh_cnt_q        <= sh_cnt_d;
      sh_inv_cnt_q    <= sh_inv_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      bitslip_q       <= bitslip_d;
      block_lock_q    <= block_lock_d;
      slip_pos_q      <= slip_pos_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    sh_cnt_d        = sh_cnt_q;
    sh_inv_cnt_d    = sh_inv_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    bitslip_d       = 1'b0;
    block_lock_d    = block_lock_q;
    slip_pos_d      = slip_pos_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    if (!i_enable) begin
      // Disable overrides every state; not counted as a lock loss.
      state_d      = ST_RESET_CNT;
      block_lock_d = 1'b0;
      sh_cnt_d     = '0;
      sh_inv_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET_CNT: begin
          sh_cnt_d     = '0;
          sh_inv_cnt_d = '0;
          state_d      = ST_TEST_SH;
        end

        ST_TEST_SH: begin
          if (aln.i_rx_hdr_valid) begin
            sh_cnt_d = sh_cnt_q + 1'b1;
            if (!hdr_ok) begin
              sh_inv_cnt_d = sh_inv_cnt_q + 1'b1;
            end
            if (block_lock_q) begin
              // Loss of lock wins over a simultaneous end of window.
              if (inv_hit) begin
                block_lock_d = 1'b0;
                if (lock_loss_cnt_q != '1) begin
                  lock_loss_cnt_d = lock_loss_cnt_q + 1'b1;
                end
                state_d = ST_SLIP;
              end else if (win_done) begin
                state_d = ST_RESET_CNT;
              end
            end else begin
              if (!hdr_ok) begin
                state_d = ST_SLIP;
              end else if (win_done) begin
                block_lock_d = 1'b1;
                state_d      = ST_RESET_CNT;
              end
            end
          end
        end

        ST_SLIP: begin
          bitslip_d  = 1'b1;
          slip_pos_d = (slip_pos_q == SH_POS_WIDTH'(FRAME_WIDTH - 1)) ?
                       '0 : slip_pos_q + 1'b1;
          wait_cnt_d = WAIT_W'(SLIP_WAIT);
          state_d    = ST_SLIP_WAIT;
        end

        ST_SLIP_WAIT: begin
          // Leave on the cycle the counter reaches zero: SLIP_WAIT cycles here.
          wait_cnt_d = (wait_cnt_q == '0) ? '0 : wait_cnt_q - 1'b1;
          if (wait_cnt_q <= WAIT_W'(1)) begin
            state_d = ST_RESET_CNT;
          end
        end

        default: state_d = ST_RESET_CNT;
      endcase
    end
  end

  assign aln.o_bitslip   = bitslip_q;
  assign o_rx_block_lock = block_lock_q;
  assign o_slip_pos      = slip_pos_q;
  assign o_lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock_ctrl.sv
// Directed bench for the 10GBASE-R block-lock controller.
module tb_eth_phy_10g_rx_block_lock_ctrl;

  localparam int unsigned POS_W = $clog2(66);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             lock;
  logic [POS_W-1:0] pos;
  logic [15:0]      loss;

  int n_pass  = 0;
  int n_total = 0;

  eth_phy_10g_rx_block_lock_ctrl_if #(.HDR_WIDTH(2)) aln_if ();

  eth_phy_10g_rx_block_lock_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_enable        (en),
    .aln             (aln_if),
    .o_rx_block_lock (lock),
    .o_slip_pos      (pos),
    .o_lock_loss_cnt (loss)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial begin
    int n;
    int t;
    int last;
    logic found;
    logic got_lock;

    rst = 1'b0;
    en  = 1'b0;
    aln_if.i_rx_hdr       = 2'b00;
    aln_if.i_rx_hdr_valid = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_bitslip", 32'(aln_if.o_bitslip), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_loss", 32'(loss), 32'd0);

    // Lock on exactly 64 valid headers (first cycle is RESET_CNT, header unused)
    rst = 1'b1;
    en  = 1'b1;
    aln_if.i_rx_hdr = 2'b01;
    aln_if.i_rx_hdr_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (aln_if.o_bitslip) n++;
      if (i == 64) check("lock_after_63", 32'(lock), 32'd0);
      aln_if.i_rx_hdr_valid = 1'b1;
    end
    tick();
    if (aln_if.o_bitslip) n++;
    check("lock_after_64", 32'(lock), 32'd1);
    check("no_slip_when_aligned", 32'(n), 32'd0);
    check("pos_aligned", 32'(pos), 32'd0);
    aln_if.i_rx_hdr_valid = 1'b0;

    // Four windows of 15 invalid headers each: lock held
    for (int w = 0; w < 4; w++) begin
      for (int p = 0; p < 64; p++) begin
        tick();
        aln_if.i_rx_hdr = (p < 60 && (p % 4) == 0) ? 2'b11 : 2'b01;
        aln_if.i_rx_hdr_valid = 1'b1;
      end
      tick();
      aln_if.i_rx_hdr_valid = 1'b0;
      check("lock_held_15inv", 32'(lock), 32'd1);
      check("loss_zero_15inv", 32'(loss), 32'd0);
    end

    // 16th invalid header is also the 64th of the window
    for (int p = 0; p < 64; p++) begin
      tick();
      aln_if.i_rx_hdr = ((p < 60 && (p % 4) == 0) || p == 63) ? 2'b11 : 2'b01;
      aln_if.i_rx_hdr_valid = 1'b1;
    end
    tick();
    aln_if.i_rx_hdr_valid = 1'b0;
    check("lock_lost_16inv", 32'(lock), 32'd0);
    check("loss_cnt_1", 32'(loss), 32'd1);
    check("no_slip_yet", 32'(aln_if.o_bitslip), 32'd0);
    tick();
    check("slip_after_loss", 32'(aln_if.o_bitslip), 32'd1);
    check("pos_after_loss", 32'(pos), 32'd1);

    // Asynchronous reset while in SLIP_WAIT_ST
    rst = 1'b0;
    #1;
    check("arst_bitslip", 32'(aln_if.o_bitslip), 32'd0);
    check("arst_lock", 32'(lock), 32'd0);
    check("arst_pos", 32'(pos), 32'd0);
    check("arst_loss", 32'(loss), 32'd0);
    tick();
    tick();

    // Invalid headers: first slip 3 edges after release, then every 11 cycles
    rst = 1'b1;
    aln_if.i_rx_hdr = 2'b11;
    aln_if.i_rx_hdr_valid = 1'b1;
    t = 0;
    last = 0;
    for (int s = 0; s < 66; s++) begin
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
        if (!found) begin
          tick();
          t++;
          found = aln_if.o_bitslip;
        end
      end
      check("slip_seen", 32'(found), 32'd1);
      if (s == 0) begin
        check("first_slip_latency", 32'(t), 32'd3);
        check("pos_first_slip", 32'(pos), 32'd1);
      end else begin
        check("slip_spacing", 32'(t - last), 32'd11);
      end
      last = t;
    end
    check("pos_wrap_66", 32'(pos), 32'd0);
    check("lock_never_unaligned", 32'(lock), 32'd0);
    tick();
    check("slip_one_cycle", 32'(aln_if.o_bitslip), 32'd0);

    // Aligner model: headers valid only at slip position 23
    n = 0;
    got_lock = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!got_lock) begin
        aln_if.i_rx_hdr = (pos == POS_W'(23)) ? 2'b01 : 2'b11;
        aln_if.i_rx_hdr_valid = 1'b1;
        tick();
        if (aln_if.o_bitslip) n++;
        if (lock) got_lock = 1'b1;
      end
    end
    check("misalign_lock", 32'(got_lock), 32'd1);
    check("misalign_slips", 32'(n), 32'd23);
    check("misalign_pos", 32'(pos), 32'd23);

    // Disable while locked: lock drops, no loss counted
    aln_if.i_rx_hdr_valid = 1'b0;
    en = 1'b0;
    tick();
    check("dis_lock", 32'(lock), 32'd0);
    check("dis_loss", 32'(loss), 32'd0);
    check("dis_bitslip", 32'(aln_if.o_bitslip), 32'd0);
    tick();
    tick();
    check("dis_lock_hold", 32'(lock), 32'd0);

    // 50% strobe duty: still exactly 64 strobed headers
    en = 1'b1;
    aln_if.i_rx_hdr = 2'b01;
    aln_if.i_rx_hdr_valid = 1'b0;
    for (int i = 1; i <= 127; i++) begin
      tick();
      if (i == 127) check("duty_lock_after_63", 32'(lock), 32'd0);
      aln_if.i_rx_hdr_valid = (i % 2) == 1;
    end
    tick();
    aln_if.i_rx_hdr_valid = 1'b0;
    check("duty_lock_after_64", 32'(lock), 32'd1);
    check("duty_pos", 32'(pos), 32'd23);
    check("duty_loss", 32'(loss), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
